// File: rtl/dds_seq_pkg.sv
// Shared types and constants for the DDS tuning-word sequencer.
// Holds the FSM state encoding, the ROM address range and the address clamp helper.
package dds_seq_pkg;

   localparam int ADDR_W           = 11;
   localparam int ADDR_MAX         = 1800;
   localparam int TW_WIDTH_DEFAULT = 32;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      WAIT_DATA = 3'd2,
      WAIT_WRAP = 3'd3,
      LOAD      = 3'd4
   } seq_state_t;

   // Indices above the last ROM entry map onto the highest valid frequency.
   function automatic logic [ADDR_W-1:0] clamp_addr(input logic [ADDR_W-1:0] addr);
      if (addr > ADDR_W'(ADDR_MAX)) begin
         return ADDR_W'(ADDR_MAX);
      end
      return addr;
   endfunction

endpackage

// File: rtl/dds_seq_counter.sv
// Loadable up-counter with a terminal-count flag.
// The counter stops at the terminal value so the flag stays asserted until the next load.
module dds_seq_counter #(
   parameter int W = 4
) (
   input  logic         Fg_CLK,
   input  logic         RESETn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] terminal,
   output logic         tc
);

   logic [W-1:0] count;

   assign tc = (count == terminal);

   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && !tc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/dds_tuning_sequencer.sv
// Fetches tuning words from the frequency ROM on rotary/mode requests and applies them
// to the phase accumulator, either at the next accumulator wrap or at once on a mode change.
module dds_tuning_sequencer
   import dds_seq_pkg::*;
#(
   parameter int TW_WIDTH     = TW_WIDTH_DEFAULT,
   parameter int ROM_LAT      = 2,
   parameter int WRAP_TIMEOUT = 4095
) (
   input  logic                Fg_CLK,
   input  logic                RESETn,
   input  logic [ADDR_W-1:0]   Address,
   input  logic                FreqChng,
   input  logic [2:0]          Mode,
   output logic                Rom_Rd,
   output logic [ADDR_W-1:0]   Rom_Addr,
   input  logic [TW_WIDTH-1:0] Rom_Data,
   input  logic                Acc_Wrap,
   output logic [TW_WIDTH-1:0] Tuning_Word,
   output logic                Tw_Load,
   output logic                Acc_Clr,
   output logic                Busy
);

   localparam int LAT_W = $clog2(ROM_LAT + 1);
   localparam int TO_W  = $clog2(WRAP_TIMEOUT + 1);

   seq_state_t          state;
   seq_state_t          next_state;
   logic [2:0]          mode_sh;
   logic                mode_chg;
   logic                req;
   logic [ADDR_W-1:0]   addr_in;
   logic [ADDR_W-1:0]   addr_next;
   logic [ADDR_W-1:0]   req_addr;
   logic                pending;
   logic                force_flag;
   logic [TW_WIDTH-1:0] word_reg;
   logic                lat_tc;
   logic                to_tc;

   assign addr_in   = clamp_addr(Address);
   assign mode_chg  = (Mode != mode_sh);
   assign req       = FreqChng || mode_chg;
   // A request arriving in the same cycle as a fetch decision wins over the stored address.
   assign addr_next = req ? addr_in : req_addr;

   dds_seq_counter #(.W(LAT_W)) u_lat_cnt (
      .Fg_CLK   (Fg_CLK),
      .RESETn   (RESETn),
      .load     (state != WAIT_DATA),
      .load_val ('0),
      .en       (state == WAIT_DATA),
      .terminal (LAT_W'(ROM_LAT - 1)),
      .tc       (lat_tc)
   );

   dds_seq_counter #(.W(TO_W)) u_wrap_cnt (
      .Fg_CLK   (Fg_CLK),
      .RESETn   (RESETn),
      .load     (state != WAIT_WRAP),
      .load_val ('0),
      .en       (state == WAIT_WRAP),
      .terminal (TO_W'(WRAP_TIMEOUT)),
      .tc       (to_tc)
   );

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:      if (req) next_state = FETCH;
         FETCH:     next_state = WAIT_DATA;
         WAIT_DATA: if (lat_tc) next_state = force_flag ? LOAD : WAIT_WRAP;
         WAIT_WRAP: if (Acc_Wrap || to_tc) next_state = LOAD;
         LOAD:      next_state = (pending || req) ? FETCH : IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // Outputs are decoded from next_state so each pulse lines up with its state.
   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) begin
         state       <= IDLE;
         mode_sh     <= '0;
         pending     <= 1'b0;
         force_flag  <= 1'b0;
         Rom_Rd      <= 1'b0;
         Rom_Addr    <= '0;
         Tuning_Word <= '0;
         Tw_Load     <= 1'b0;
         Acc_Clr     <= 1'b0;
         Busy        <= 1'b0;
      end else begin
         state   <= next_state;
         mode_sh <= Mode;
         Rom_Rd  <= (next_state == FETCH);
         Tw_Load <= (next_state == LOAD);
         Acc_Clr <= (next_state == LOAD) && force_flag;
         Busy    <= (next_state != IDLE);

         if (next_state == FETCH) begin
            Rom_Addr <= addr_next;
         end
         // Forced loads leave WAIT_DATA straight into LOAD, so bypass the word register.
         if (next_state == LOAD) begin
            Tuning_Word <= (state == WAIT_DATA) ? Rom_Data : word_reg;
         end

         if (next_state == FETCH) begin
            pending <= 1'b0;
         end else if (req && (state != IDLE)) begin
            pending <= 1'b1;
         end

         if (state == LOAD) begin
            force_flag <= mode_chg;
         end else if (mode_chg) begin
            force_flag <= 1'b1;
         end
      end
   end

   always_ff @(posedge Fg_CLK) begin
      if (req) begin
         req_addr <= addr_in;
      end
      if ((state == WAIT_DATA) && lat_tc) begin
         word_reg <= Rom_Data;
      end
   end

endmodule

// File: tb/tb_dds_tuning_sequencer.sv
// Directed bench for dds_tuning_sequencer with a latency-accurate ROM model and
// a scoreboard of expected fetch addresses and loaded tuning words.
module tb_dds_tuning_sequencer;

   localparam int TW  = 32;
   localparam int LAT = 2;
   localparam int TMO = 16;

   logic          Fg_CLK   = 1'b0;
   logic          RESETn   = 1'b1;
   logic [10:0]   Address  = '0;
   logic          FreqChng = 1'b0;
   logic [2:0]    Mode     = '0;
   logic          Acc_Wrap = 1'b0;
   logic          Rom_Rd;
   logic [10:0]   Rom_Addr;
   logic [TW-1:0] Rom_Data;
   logic [TW-1:0] Tuning_Word;
   logic          Tw_Load;
   logic          Acc_Clr;
   logic          Busy;

   int vectors     = 0;
   int miscompares = 0;

   logic [TW:0]   exp_load_q[$];
   logic [10:0]   exp_fetch_q[$];
   logic [TW:0]   ld_exp;
   logic [10:0]   fa_exp;
   logic [TW-1:0] rom_pipe[LAT];

   always #5 Fg_CLK = ~Fg_CLK;

   dds_tuning_sequencer #(
      .TW_WIDTH     (TW),
      .ROM_LAT      (LAT),
      .WRAP_TIMEOUT (TMO)
   ) dut (
      .Fg_CLK      (Fg_CLK),
      .RESETn      (RESETn),
      .Address     (Address),
      .FreqChng    (FreqChng),
      .Mode        (Mode),
      .Rom_Rd      (Rom_Rd),
      .Rom_Addr    (Rom_Addr),
      .Rom_Data    (Rom_Data),
      .Acc_Wrap    (Acc_Wrap),
      .Tuning_Word (Tuning_Word),
      .Tw_Load     (Tw_Load),
      .Acc_Clr     (Acc_Clr),
      .Busy        (Busy)
   );

   // ROM contents are address*16; data is only valid exactly LAT cycles after a read.
   always @(posedge Fg_CLK) begin
      rom_pipe[0] <= Rom_Rd ? (TW'(Rom_Addr) << 4) : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign Rom_Data = rom_pipe[LAT-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Fg_CLK);
      #1;
   endtask

   task automatic expect_load(input logic [TW-1:0] tw, input logic clr);
      exp_load_q.push_back({clr, tw});
   endtask

   task automatic run_to_load(input int wrap_at, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 1; i <= 60 && !seen; i++) begin
         Acc_Wrap = (i == wrap_at);
         step();
         if (Tw_Load) seen = 1'b1;
      end
      Acc_Wrap = 1'b0;
      chk(tag, 64'(seen), 64'd1);
   endtask

   always @(negedge Fg_CLK) begin
      if (Rom_Rd) begin
         if (exp_fetch_q.size() == 0) begin
            chk("unexpected_fetch", 64'(Rom_Rd), 64'd0);
         end else begin
            fa_exp = exp_fetch_q.pop_front();
            chk("fetch_addr", 64'(Rom_Addr), 64'(fa_exp));
         end
      end
      if (Tw_Load) begin
         if (exp_load_q.size() == 0) begin
            chk("unexpected_load", 64'(Tw_Load), 64'd0);
         end else begin
            ld_exp = exp_load_q.pop_front();
            chk("load_word", 64'(Tuning_Word), 64'(ld_exp[TW-1:0]));
            chk("load_clr", 64'(Acc_Clr), 64'(ld_exp[TW]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired vectors=%0d", vectors);
      $fatal(1);
   end

   initial begin
      #1 RESETn = 1'b0;
      repeat (3) step();
      chk("reset_outputs", 64'({Rom_Rd, Rom_Addr, Tuning_Word, Tw_Load, Acc_Clr, Busy}), 64'd0);
      RESETn = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         chk("idle_after_reset", 64'({Rom_Rd, Rom_Addr, Tuning_Word, Tw_Load, Acc_Clr, Busy}), 64'd0);
      end

      // Normal path: load one cycle after the wrap.
      Address = 11'd500; FreqChng = 1'b1;
      exp_fetch_q.push_back(11'd500);
      expect_load(32'h0000_1F40, 1'b0);
      step();
      FreqChng = 1'b0;
      chk("fetch_strobe", 64'(Rom_Rd), 64'd1);
      chk("fetch_addr_500", 64'(Rom_Addr), 64'd500);
      chk("busy_in_fetch", 64'(Busy), 64'd1);
      step();
      chk("strobe_one_cycle", 64'(Rom_Rd), 64'd0);
      chk("rom_addr_held", 64'(Rom_Addr), 64'd500);
      step(); step();
      for (int i = 0; i < 9; i++) begin
         step();
         chk("no_load_before_wrap", 64'(Tw_Load), 64'd0);
      end
      Acc_Wrap = 1'b1;
      step();
      Acc_Wrap = 1'b0;
      chk("load_after_wrap", 64'(Tw_Load), 64'd1);
      chk("tw_500", 64'(Tuning_Word), 64'h1F40);
      chk("clr_normal", 64'(Acc_Clr), 64'd0);
      step();
      chk("load_one_cycle", 64'(Tw_Load), 64'd0);
      chk("idle_after_load", 64'(Busy), 64'd0);
      chk("tw_holds", 64'(Tuning_Word), 64'h1F40);

      // Wrap on the capture edge is ignored; timeout forces the load.
      Address = 11'd1000; FreqChng = 1'b1;
      exp_fetch_q.push_back(11'd1000);
      expect_load(32'd16000, 1'b0);
      step();
      FreqChng = 1'b0;
      step(); step();
      Acc_Wrap = 1'b1;
      step();
      Acc_Wrap = 1'b0;
      chk("capture_wrap_ignored", 64'(Tw_Load), 64'd0);
      for (int i = 1; i <= TMO; i++) begin
         step();
         chk("no_load_before_timeout", 64'(Tw_Load), 64'd0);
      end
      step();
      chk("timeout_load", 64'(Tw_Load), 64'd1);
      chk("tw_1000", 64'(Tuning_Word), 64'd16000);
      step();

      // Three requests in one busy sequence: only first and latest are served.
      Address = 11'd100; FreqChng = 1'b1;
      exp_fetch_q.push_back(11'd100);
      expect_load(32'd1600, 1'b0);
      step();
      FreqChng = 1'b0;
      step();
      Address = 11'd200; FreqChng = 1'b1;
      step();
      FreqChng = 1'b0;
      step();
      Address = 11'd300; FreqChng = 1'b1;
      step();
      FreqChng = 1'b0;
      exp_fetch_q.push_back(11'd300);
      expect_load(32'd4800, 1'b0);
      run_to_load(3, "load_100_seen");
      step();
      chk("pending_fetch", 64'(Rom_Rd), 64'd1);
      chk("pending_addr_300", 64'(Rom_Addr), 64'd300);
      chk("pending_busy", 64'(Busy), 64'd1);
      run_to_load(6, "load_300_seen");
      step();
      chk("idle_after_pending", 64'(Busy), 64'd0);

      // Out-of-range address clamps; request in LOAD goes straight to FETCH.
      Address = 11'd2000; FreqChng = 1'b1;
      exp_fetch_q.push_back(11'd1800);
      expect_load(32'd28800, 1'b0);
      step();
      FreqChng = 1'b0;
      chk("clamp_addr", 64'(Rom_Addr), 64'd1800);
      run_to_load(6, "load_clamped_seen");
      Address = 11'd42; FreqChng = 1'b1;
      exp_fetch_q.push_back(11'd42);
      expect_load(32'd672, 1'b0);
      step();
      FreqChng = 1'b0;
      chk("fetch_after_load", 64'(Rom_Rd), 64'd1);
      chk("busy_no_gap", 64'(Busy), 64'd1);
      run_to_load(6, "load_42_seen");
      step();

      // Reset while waiting for the wrap.
      Address = 11'd900; FreqChng = 1'b1;
      exp_fetch_q.push_back(11'd900);
      step();
      FreqChng = 1'b0;
      repeat (4) step();
      chk("busy_before_reset", 64'(Busy), 64'd1);
      RESETn = 1'b0;
      #1;
      chk("reset_async_clear", 64'({Busy, Rom_Rd, Tw_Load, Acc_Clr, Tuning_Word}), 64'd0);
      Acc_Wrap = 1'b1;
      step();
      Acc_Wrap = 1'b0;
      step();
      RESETn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         Acc_Wrap = ((i % 5) == 2);
         step();
         chk("no_load_after_reset", 64'({Tw_Load, Busy, Tuning_Word}), 64'd0);
      end
      Acc_Wrap = 1'b0;
      Address = 11'd50; FreqChng = 1'b1;
      exp_fetch_q.push_back(11'd50);
      expect_load(32'd800, 1'b0);
      step();
      FreqChng = 1'b0;
      chk("fetch_after_reset", 64'(Rom_Rd), 64'd1);
      run_to_load(6, "load_after_reset_seen");
      step();

      // Mode change alone: refetch current address and force an immediate load.
      Address = 11'd700; Mode = 3'd4;
      exp_fetch_q.push_back(11'd700);
      expect_load(32'd11200, 1'b1);
      step();
      chk("mode_fetch", 64'(Rom_Rd), 64'd1);
      chk("mode_fetch_addr", 64'(Rom_Addr), 64'd700);
      step();
      chk("mode_no_early_load_1", 64'(Tw_Load), 64'd0);
      step();
      chk("mode_no_early_load_2", 64'(Tw_Load), 64'd0);
      step();
      chk("mode_load_k4", 64'(Tw_Load), 64'd1);
      chk("mode_acc_clr", 64'(Acc_Clr), 64'd1);
      chk("mode_tw_700", 64'(Tuning_Word), 64'd11200);
      step();
      chk("mode_clr_one_cycle", 64'(Acc_Clr), 64'd0);
      repeat (5) step();
      chk("mode_single_request", 64'(Busy), 64'd0);

      chk("fetch_queue_drained", 64'(exp_fetch_q.size()), 64'd0);
      chk("load_queue_drained", 64'(exp_load_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
